// File: rtl/down_counter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | down_counter_ctrl : load/start/pause sequencer for the 8-bit down-counter |
// |                     display path, with prescaled count and digit scan.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module down_counter_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] count,
  output logic       running,
  output logic       done,
  output logic       tick,
  output logic       digit_sel,
  output logic [3:0] digit
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;

  logic [2:0]    state_q,  state_d;
  logic [7:0]    count_q,  count_d;
  logic [7:0]    reload_q, reload_d;
  logic [PW-1:0] presc_q,  presc_d;
  logic          tick_q,   tick_d;
  logic [SW-1:0] scan_q,   scan_d;
  logic          sel_q,    sel_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      presc_d  = '0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            presc_d = '0;
            state_d = (count_q != 8'd0) ? ST_COUNT : ST_DONE;
          end
        end

        ST_COUNT: begin
          // The pause edge itself does not advance the prescaler, so the
          // phase held in PAUSE is exactly the one seen when pause arrived.
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (count_q == 8'd0) begin
            state_d = ST_DONE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = count_q - 8'd1;
            tick_d  = 1'b1;
            if (count_q == 8'd1) begin
              state_d = ST_DONE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        ST_PAUSE: begin
          if (pause) begin
            state_d = ST_COUNT;
          end
        end

        ST_DONE: begin
          if (start) begin
            count_d = reload_q;
            presc_d = '0;
            state_d = (reload_q != 8'd0) ? ST_COUNT : ST_DONE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Digit scan runs free, independent of the counter state machine.
  always_comb begin
    sel_d = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end else begin
      scan_d = scan_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= 8'd0;
      reload_q <= 8'd0;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      scan_q   <= '0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      scan_q   <= scan_d;
      sel_q    <= sel_d;
    end
  end

  assign count     = count_q;
  assign running   = (state_q == ST_COUNT);
  assign done      = (state_q == ST_DONE);
  assign tick      = tick_q;
  assign digit_sel = sel_q;
  assign digit     = sel_q ? count_q[7:4] : count_q[3:0];

endmodule
`default_nettype wire
